// File: rtl/pe_out_collect.sv
// pe_out_collect
//   Collects the LANES neuron outputs that the PE produces for each tile.
//   Tiles are assembled into a reservoir state frame of NUM_NEURONS values.
//   Storage is double-buffered: the write bank fills from the PE while the
//   read bank holds the last complete frame for the input loader.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   in_valid        a PE tile is present on in_data
//   in_ready        the block can accept a tile this cycle
//   in_data         LANES x DW; lane k is bits [k*DW +: DW] (PE Q<k>)
//   flush           discard the write bank's partial or full contents
//   frame_valid     the read bank holds a complete frame
//   frame_release   the consumer is finished with the read bank
//   rd_addr         neuron index to read from the read bank
//   rd_data         registered read data (1-cycle latency)
//   tile_idx        next tile slot to be written
//   frame_cnt       number of completed bank swaps (wraps)
module pe_out_collect #(
  parameter int NUM_NEURONS = 64,
  parameter int LANES       = 4,
  parameter int DW          = 16,
  parameter int AW          = 6,
  localparam int TILES      = NUM_NEURONS / LANES,
  localparam int TW         = (TILES > 1) ? $clog2(TILES) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [LANES*DW-1:0] in_data,
  input  logic                flush,
  output logic                frame_valid,
  input  logic                frame_release,
  input  logic [AW-1:0]       rd_addr,
  output logic [DW-1:0]       rd_data,
  output logic [TW-1:0]       tile_idx,
  output logic [15:0]         frame_cnt
);

  typedef enum logic {FILL, FULL} state_t;

  state_t        state, state_nx;
  logic          wr_bank, bank_nx;
  logic [TW-1:0] tile_nx;
  logic          fv_nx;
  logic [15:0]   cnt_nx;
  logic          accept, last, swap;

  // Each bank is sized to the full address space so that out-of-range
  // addresses never index past the array; such reads are forced to zero.
  logic [DW-1:0] bank0 [0:(1<<AW)-1];
  logic [DW-1:0] bank1 [0:(1<<AW)-1];

  assign in_ready = (state == FILL) && !rst;

  always_comb begin
    accept   = in_valid && in_ready && !flush;
    last     = accept && (tile_idx == TW'(TILES - 1));
    // A swap hands the freshly completed write bank to the reader. A flush
    // discards the write bank, so it can never be swapped in that cycle.
    swap     = !flush && ((last && (!frame_valid || frame_release)) ||
                          ((state == FULL) && frame_release));
    state_nx = state;
    tile_nx  = tile_idx;
    bank_nx  = wr_bank;
    fv_nx    = frame_valid;
    cnt_nx   = frame_cnt;

    if (flush) begin
      tile_nx  = '0;
      state_nx = FILL;
    end else if (accept) begin
      tile_nx = last ? '0 : tile_idx + 1'b1;
      if (last && !swap) state_nx = FULL;
    end else if ((state == FULL) && frame_release) begin
      state_nx = FILL;
    end

    if (swap) begin
      bank_nx = ~wr_bank;
      fv_nx   = 1'b1;
      cnt_nx  = frame_cnt + 16'd1;
    end else if (frame_release) begin
      fv_nx   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FILL;
      tile_idx    <= '0;
      wr_bank     <= 1'b0;
      frame_valid <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      state       <= state_nx;
      tile_idx    <= tile_nx;
      wr_bank     <= bank_nx;
      frame_valid <= fv_nx;
      frame_cnt   <= cnt_nx;
    end
  end

  // Write stage: all lanes of an accepted tile land in one cycle.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < LANES; k++) begin
        if (wr_bank)
          bank1[AW'(int'(tile_idx) * LANES + k)] <= in_data[k*DW +: DW];
        else
          bank0[AW'(int'(tile_idx) * LANES + k)] <= in_data[k*DW +: DW];
      end
    end
  end

  // Read stage: registered, from the bank not being written.
  always_ff @(posedge clk) begin
    if (rst)
      rd_data <= '0;
    else if (int'(rd_addr) < NUM_NEURONS)
      rd_data <= wr_bank ? bank0[rd_addr] : bank1[rd_addr];
    else
      rd_data <= '0;
  end

endmodule

// File: tb/tb_pe_out_collect.sv
module tb_pe_out_collect;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [63:0] in_data = '0;
  logic        flush = 1'b0;
  logic        frame_release = 1'b0;
  logic [3:0]  rd_addr = '0;
  logic [3:0]  rd_addr_b = '0;

  logic        in_ready, frame_valid;
  logic [15:0] rd_data, frame_cnt;
  logic [1:0]  tile_idx;
  logic        in_ready_b, frame_valid_b;
  logic [15:0] rd_data_b, frame_cnt_b;
  logic [1:0]  tile_idx_b;

  always #5 clk = ~clk;

  pe_out_collect #(.NUM_NEURONS(16), .LANES(4), .DW(16), .AW(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .flush(flush), .frame_valid(frame_valid),
    .frame_release(frame_release), .rd_addr(rd_addr), .rd_data(rd_data),
    .tile_idx(tile_idx), .frame_cnt(frame_cnt)
  );

  // Second instance exercises out-of-range reads (12 neurons, 4-bit address).
  pe_out_collect #(.NUM_NEURONS(12), .LANES(4), .DW(16), .AW(4)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_data(in_data), .flush(flush), .frame_valid(frame_valid_b),
    .frame_release(frame_release), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
    .tile_idx(tile_idx_b), .frame_cnt(frame_cnt_b)
  );

  typedef struct {
    logic        fv;
    logic        rdy;
    logic [15:0] cnt;
    logic [1:0]  tidx;
    string       tag;
  } st_t;

  typedef struct {
    bit          which;
    logic [15:0] v;
    string       tag;
  } rd_t;

  st_t st_q[$];
  rd_t rd_q[$];
  logic st_chk = 1'b0;
  logic rd_chk = 1'b0;
  int total = 0;
  int bad = 0;

  function automatic logic [63:0] mk(int t, logic [15:0] base);
    logic [63:0] r;
    for (int k = 0; k < 4; k++) r[k*16 +: 16] = base + 16'(t * 256 + k);
    return r;
  endfunction

  // Expected state visible after the upcoming clock edge.
  task automatic exp_stat(logic fv, logic rdy, logic [15:0] cnt, logic [1:0] tidx, string tag);
    st_t e;
    e.fv = fv; e.rdy = rdy; e.cnt = cnt; e.tidx = tidx; e.tag = tag;
    st_q.push_back(e);
    st_chk = 1'b1;
  endtask

  task automatic exp_rd(bit which, logic [15:0] v, string tag);
    rd_t e;
    e.which = which; e.v = v; e.tag = tag;
    rd_q.push_back(e);
    rd_chk = 1'b1;
  endtask

  task automatic cyc();
    @(negedge clk);
    st_chk = 1'b0; rd_chk = 1'b0;
    in_valid = 1'b0; flush = 1'b0; frame_release = 1'b0;
  endtask

  task automatic send(int t, logic [15:0] base);
    in_valid = 1'b1;
    in_data  = mk(t, base);
  endtask

  // Monitor: compares DUT outputs just after each edge where a check was armed.
  always begin
    logic s, r;
    st_t  se;
    rd_t  re;
    logic [15:0] got;
    @(posedge clk);
    s = st_chk; r = rd_chk;
    #1;
    if (s) begin
      total++;
      if (st_q.size() == 0) begin
        bad++; $display("FAIL %s: status queue empty", "stat");
      end else begin
        se = st_q.pop_front();
        if (frame_valid !== se.fv || in_ready !== se.rdy ||
            frame_cnt !== se.cnt || tile_idx !== se.tidx) begin
          bad++;
          $display("FAIL %s: got fv=%b rdy=%b cnt=%0d tidx=%0d want fv=%b rdy=%b cnt=%0d tidx=%0d",
                   se.tag, frame_valid, in_ready, frame_cnt, tile_idx,
                   se.fv, se.rdy, se.cnt, se.tidx);
        end
      end
    end
    if (r) begin
      total++;
      if (rd_q.size() == 0) begin
        bad++; $display("FAIL %s: read queue empty", "rd");
      end else begin
        re = rd_q.pop_front();
        got = re.which ? rd_data_b : rd_data;
        if (got !== re.v) begin
          bad++;
          $display("FAIL %s: got rd_data=%h want %h", re.tag, got, re.v);
        end
      end
    end
  end

  initial begin
    // Reset
    rst = 1'b1; cyc();
    rst = 1'b1; exp_stat(0, 0, 0, 0, "reset"); exp_rd(0, 16'h0000, "reset_rd"); cyc();
    rst = 1'b0;

    // Frame 1: four back-to-back tiles
    for (int t = 0; t < 4; t++) begin
      send(t, 16'h0000);
      if (t == 3) exp_stat(1, 1, 1, 0, "frame1_done");
      else        exp_stat(0, 1, 0, 2'(t + 1), "frame1_fill");
      cyc();
    end
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a);
      exp_rd(0, 16'(256 * (a / 4) + (a % 4)), "frame1_rd");
      cyc();
    end
    rd_addr_b = 4'd11; exp_rd(1, 16'h0203, "b_last_in_range"); cyc();
    rd_addr_b = 4'd12; exp_rd(1, 16'h0000, "b_out_of_range");  cyc();

    // Frame 2 fills with no release: stall in FULL
    for (int t = 0; t < 4; t++) begin
      send(t, 16'h1000);
      if (t == 3) exp_stat(1, 0, 1, 0, "frame2_full");
      else        exp_stat(1, 1, 1, 2'(t + 1), "frame2_fill");
      cyc();
    end
    send(0, 16'h2000); rd_addr = 4'd5;
    exp_stat(1, 0, 1, 0, "full_reject"); exp_rd(0, 16'h0101, "hold_frame1");
    cyc();
    frame_release = 1'b1; exp_stat(1, 1, 2, 0, "release_from_full"); cyc();
    rd_addr = 4'd5; exp_rd(0, 16'h1101, "frame2_rd5"); cyc();
    rd_addr = 4'd0; exp_rd(0, 16'h1000, "frame2_rd0"); cyc();

    // Frame 3: last tile coincides with release
    for (int t = 0; t < 4; t++) begin
      send(t, 16'h3000);
      if (t == 3) begin
        frame_release = 1'b1;
        exp_stat(1, 1, 3, 0, "last_with_release");
      end else begin
        exp_stat(1, 1, 2, 2'(t + 1), "frame3_fill");
      end
      cyc();
    end
    rd_addr = 4'd5;  exp_rd(0, 16'h3101, "frame3_rd5");  cyc();
    rd_addr = 4'd15; exp_rd(0, 16'h3303, "frame3_rd15"); cyc();

    // Flush after two tiles, with a tile presented on the flush cycle
    send(0, 16'h4000); exp_stat(1, 1, 3, 1, "pre_flush0"); cyc();
    send(1, 16'h4000); exp_stat(1, 1, 3, 2, "pre_flush1"); cyc();
    send(2, 16'h5000); flush = 1'b1; exp_stat(1, 1, 3, 0, "flush"); cyc();
    for (int t = 0; t < 4; t++) begin
      send(t, 16'h6000);
      if (t == 3) begin
        frame_release = 1'b1;
        exp_stat(1, 1, 4, 0, "post_flush_done");
      end else begin
        exp_stat(1, 1, 3, 2'(t + 1), "post_flush_fill");
      end
      cyc();
    end
    rd_addr = 4'd8; exp_rd(0, 16'h6200, "post_flush_rd8"); cyc();
    rd_addr = 4'd9; exp_rd(0, 16'h6201, "post_flush_rd9"); cyc();

    // Release in FILL drops frame_valid; release with no frame is ignored
    frame_release = 1'b1; exp_stat(0, 1, 4, 0, "release_fill"); cyc();
    frame_release = 1'b1; exp_stat(0, 1, 4, 0, "release_idle"); cyc();

    // Reach FULL with a held frame, then reset
    for (int t = 0; t < 4; t++) begin
      send(t, 16'h7000);
      if (t == 3) exp_stat(1, 1, 5, 0, "frame7_done");
      else        exp_stat(0, 1, 4, 2'(t + 1), "frame7_fill");
      cyc();
    end
    for (int t = 0; t < 4; t++) begin
      send(t, 16'h8000);
      if (t == 3) exp_stat(1, 0, 5, 0, "frame8_full");
      else        exp_stat(1, 1, 5, 2'(t + 1), "frame8_fill");
      cyc();
    end
    rst = 1'b1; rd_addr = 4'd3;
    exp_stat(0, 0, 0, 0, "reset_in_full"); exp_rd(0, 16'h0000, "reset_rd_clear");
    cyc();
    rst = 1'b0; exp_stat(0, 1, 0, 0, "after_reset"); cyc();

    cyc(); cyc();
    total++;
    if (st_q.size() != 0 || rd_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got st=%0d rd=%0d pending want 0", st_q.size(), rd_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pe_out_collect.md
Name: pe_out_collect

Overview:
- Downstream of the 16x4 processing element. Captures the 4 transfer-function neuron outputs the PE produces per tile (Q0..Q3).
- Assembles them, tile by tile, into a complete reservoir state frame of NUM_NEURONS values.
- Double-buffered: one bank fills from the PE while the other holds the last complete frame for the next-timestep input loader, which reads it by address.
- Valid/ready on the input side; frame_valid/frame_release on the read side.

Parameters:
- NUM_NEURONS, 64, neurons per frame; must be a multiple of LANES.
- LANES, 4, neuron outputs per PE tile.
- DW, 16, neuron output width.
- AW, 6, read address width; must satisfy 2^AW >= NUM_NEURONS.
- Derived: TILES = NUM_NEURONS/LANES.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  PE tile outputs present on in_data.
- in_ready  out  1  block can accept a tile this cycle.
- in_data  in  LANES*DW  lane k = bits [k*DW+DW-1 : k*DW], corresponds to PE Q<k>.
- flush  in  1  discard the partially or fully filled write bank.
- frame_valid  out  1  read bank holds a complete frame.
- frame_release  in  1  consumer is finished with the read bank.
- rd_addr  in  AW  neuron index to read from the read bank.
- rd_data  out  DW  registered read data.
- tile_idx  out  log2(TILES) (min 1)  next tile slot to be written.
- frame_cnt  out  16  number of completed frame swaps.

Behaviour:
- Reset (rst=1 at edge):
  - tile_idx=0, wr_bank=0, write FSM=FILL, in_ready=1.
  - frame_valid=0, rd_data=0, frame_cnt=0.
  - Bank contents are not cleared. Reset overrides every other input, including mid-fill and mid-hold.
- Write FSM states: FILL and FULL.
  - in_ready = (state==FILL) && !rst.
- Accept (FILL, in_valid & in_ready, no flush):
  - Lane k is written to wr_bank at address tile_idx*LANES+k.
  - If tile_idx < TILES-1: tile_idx increments.
- Last tile accepted (tile_idx==TILES-1):
  - tile_idx returns to 0.
  - If frame_valid==0, or frame_release=1 in the same cycle: swap. wr_bank toggles, frame_valid=1 next cycle, frame_cnt+1 (wraps at 2^16), FSM stays in FILL.
  - Otherwise: FSM goes to FULL and in_ready=0 from the next cycle.
- FULL:
  - frame_release=1 triggers a swap (toggle, frame_cnt+1, frame_valid remains 1). FSM returns to FILL; in_ready=1 the next cycle.
- frame_release in FILL while frame_valid=1: frame_valid=0 next cycle.
- frame_release while frame_valid=0: ignored.
- flush (priority over accept):
  - tile_idx=0 and FSM=FILL next cycle; a tile presented in the same cycle is dropped.
  - The read bank, frame_valid and frame_cnt are unaffected. A frame_release in the same cycle is still honoured for frame_valid.
- Read path:
  - rd_data is registered with 1-cycle latency from rd_addr, taken from bank !wr_bank as sampled before the edge.
  - rd_addr >= NUM_NEURONS gives rd_data=0.
  - rd_data updates every cycle regardless of frame_valid.
- Data is stored verbatim; no arithmetic, saturation or reordering.
- Throughput: one tile per cycle sustained, provided the consumer releases within TILES cycles of frame_valid.

Test Plan:
All scenarios use NUM_NEURONS=16, LANES=4, TILES=4, AW=4.
- Reset then 4 back-to-back tiles, tile t lane k = 16'h0100*t+k:
  - frame_valid=1 the cycle after the 4th accept; frame_cnt=1; tile_idx=0.
  - Reading addr 0..15 yields 0000,0001,0002,0003,0100,...,0303, each 1 cycle after the address.
- With frame_valid held and no release, stream 4 more tiles (values +16'h1000):
  - in_ready=0 after the 4th; a 5th valid tile is not accepted; reads still return frame 1.
  - Pulse frame_release: next cycle in_ready=1, frame_cnt=2; addr 5 reads 1101.
- Last tile accepted in the same cycle as frame_release with frame_valid=1:
  - No FULL stall; frame_cnt increments once; frame_valid stays 1; new frame readable.
- flush after 2 tiles, asserted with in_valid=1:
  - tile_idx=0, that tile dropped, frame_valid and frame_cnt unchanged.
  - A subsequent 4 tiles complete a frame normally.
- rst asserted while in FULL with frame_valid=1:
  - Next cycle frame_valid=0, in_ready=1, frame_cnt=0, rd_data=0.
- rd_addr=15 gives the last lane value; rd_addr stays within 4 bits, so out-of-range is covered via NUM_NEURONS=12 with rd_addr=12 -> rd_data=0.
